barrel_shift_seq: RTL and testbench
===================================

// Module: barrel_shift_seq
// PURPOSE
//  Parametrised sequenced barrel shifter/rotator. Generalises the single-step
//  left-rotate register: adds selectable direction and mode, plus a multi-position
//  shift command with a start/busy/done handshake, applying up to STEP positions
//  per clock. Serves as the datapath shift unit for controller/ALU blocks.
// PARAMETERS
//  WIDTH   8   data width in bits (>= 2)
//  STEP    1   max positions shifted per clock (1..WIDTH)
//  AMT_W   $clog2(WIDTH)+1   width of amount port (derived, do not override)
// PORTS
//  clock     in   1       rising-edge clock
//  reset     in   1       asynchronous, active-high reset
//  load      in   1       parallel load of data_in (IDLE only)
//  data_in   in   WIDTH   parallel load data
//  start     in   1       begin shift command (IDLE only)
//  mode      in   3       000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, 101-111 reserved
//  amount    in   AMT_W   total positions to shift; values > WIDTH clamp to WIDTH
//  data_out  out  WIDTH   shift register contents
//  busy      out  1       high while in SHIFT
//  done      out  1       one-cycle pulse: command complete
//  carry_out out  1       last bit shifted out (only with BSR_CARRY_EN)
// BEHAVIOUR
//  - Reset: data_out=0, busy=0, done=0, carry_out=0, state IDLE, remaining=0.
//    Reset mid-command aborts immediately; no done pulse.
//  - States: IDLE -> SHIFT -> DONE -> IDLE. The 0-amount path is IDLE -> DONE.
//  - IDLE, load=1: data_out<=data_in at the edge; carry_out<=0. Load wins over start
//    in the same cycle, and that start is dropped.
//  - IDLE, start=1, load=0: latch mode and clamped amount into remaining.
//    If remaining==0, go to DONE; data unchanged.
//    Otherwise go to SHIFT; busy is high from the next cycle.
//  - SHIFT, each edge: k=min(STEP,remaining); shift data_out by k per latched mode;
//    remaining-=k. When remaining becomes 0, go to DONE.
//    Busy cycles = ceil(amount/STEP).
//  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
//    A new start is accepted in the first cycle after done.
//  - load/start/mode/amount are ignored in SHIFT and DONE (no queuing).
//  - Mode semantics per position:
//      ROL  {d[W-2:0],d[W-1]}
//      ROR  {d[0],d[W-1:1]}
//      SLL  {d[W-2:0],0}
//      SRL  {0,d[W-1:1]}
//      SRA  {d[W-1],d[W-1:1]}
//  - Shift by WIDTH: ROL/ROR return the original value; SLL/SRL give 0;
//    SRA gives all copies of the sign bit.
//  - Reserved modes: same timing and handshake as a normal command; data held;
//    carry_out held.
//  - outputs registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  BSR_CARRY_EN defined: carry_out port present. carry_out is updated on every SHIFT
//    edge to the last bit leaving the MSB (left modes) or LSB (right modes). For
//    rotates, this is the wrapped bit. It holds between commands and clears on load
//    and reset.
//  BSR_CARRY_EN undefined: carry_out port and its logic are absent; all other
//    behaviour is identical.
// TESTING (WIDTH=8, STEP=1 unless noted)
//  1 load A5, start ROL amt=1 -> busy 1 cycle, data_out=4B, done pulse; carry_out=1.
//  2 load 81, start ROR amt=3 -> busy 3 cycles, data_out C0,60,30; done; carry_out=0.
//  3 STEP=4: load 90, start SRA amt=4 -> busy 1 cycle, data_out=F9, done once.
//  4 load FF, start SLL amt=9 (clamped to 8) -> busy 8 cycles, data_out=00;
//    start amt=0 -> done next cycle with no busy, data_out unchanged.
//  5 load+start same cycle (data_in=3C) -> data_out=3C, no busy, no done;
//    start during SHIFT is ignored.
//  6 reset asserted on the 2nd SHIFT cycle of ROL amt=5 -> all outputs 0 immediately,
//    IDLE, no done.

Source files
------------

// File: rtl/barrel_shift_seq.sv
// Sequenced barrel shifter/rotator with start/busy/done handshake.
// Applies up to STEP positions per clock until the clamped amount is consumed.
// Optional feature macro: BSR_CARRY_EN adds the carry_out port and its register.
module barrel_shift_seq #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned STEP  = 1,
   parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amount,
   output logic [WIDTH-1:0] data_out,
   output logic             busy,
`ifdef BSR_CARRY_EN
   output logic             done,
   output logic             carry_out
`else
   output logic             done
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      MODE_ROL = 3'b000,
      MODE_ROR = 3'b001,
      MODE_SLL = 3'b010,
      MODE_SRL = 3'b011,
      MODE_SRA = 3'b100
   } mode_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] data_q;
   logic [AMT_W-1:0] remaining_q;
   mode_t            mode_q;
   logic [AMT_W-1:0] amt_clamped;
   logic [AMT_W-1:0] step_k;
   logic [AMT_W-1:0] remaining_next;
   logic [WIDTH-1:0] shifted;
`ifdef BSR_CARRY_EN
   logic             carry_q;
   logic             shift_carry;
`endif

   // Clamp the requested amount and size this cycle's step.
   always_comb begin
      amt_clamped    = (amount > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amount;
      step_k         = (remaining_q > AMT_W'(STEP)) ? AMT_W'(STEP) : remaining_q;
      remaining_next = remaining_q - step_k;
   end

   // Apply step_k single-position shifts; reserved modes leave data and carry as is.
   always_comb begin
      shifted = data_q;
`ifdef BSR_CARRY_EN
      shift_carry = carry_q;
`endif
      for (int unsigned i = 0; i < STEP; i++) begin
         if (AMT_W'(i) < step_k) begin
            case (mode_q)
               MODE_ROL, MODE_SLL: begin
`ifdef BSR_CARRY_EN
                  shift_carry = shifted[WIDTH-1];
`endif
                  shifted = {shifted[WIDTH-2:0],
                             (mode_q == MODE_ROL) ? shifted[WIDTH-1] : 1'b0};
               end
               MODE_ROR, MODE_SRL, MODE_SRA: begin
`ifdef BSR_CARRY_EN
                  shift_carry = shifted[0];
`endif
                  case (mode_q)
                     MODE_ROR: shifted = {shifted[0], shifted[WIDTH-1:1]};
                     MODE_SRA: shifted = {shifted[WIDTH-1], shifted[WIDTH-1:1]};
                     default:  shifted = {1'b0, shifted[WIDTH-1:1]};
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

   // Next-state logic for the IDLE -> SHIFT -> DONE -> IDLE sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start && !load) begin
               state_d = (amt_clamped == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (remaining_next == '0) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register; reset aborts any command in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath: load/latch in IDLE, shift in SHIFT, hold otherwise.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_q      <= '0;
         remaining_q <= '0;
         mode_q      <= MODE_ROL;
`ifdef BSR_CARRY_EN
         carry_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (load) begin
                  data_q  <= data_in;
`ifdef BSR_CARRY_EN
                  carry_q <= 1'b0;
`endif
               end else if (start) begin
                  mode_q      <= mode_t'(mode);
                  remaining_q <= amt_clamped;
               end
            end
            SHIFT: begin
               data_q      <= shifted;
               remaining_q <= remaining_next;
`ifdef BSR_CARRY_EN
               carry_q     <= shift_carry;
`endif
            end
            default: ;
         endcase
      end
   end

   assign data_out = data_q;
   assign busy     = (state_q == SHIFT);
   assign done     = (state_q == DONE);
`ifdef BSR_CARRY_EN
   assign carry_out = carry_q;
`endif

endmodule

// File: tb/tb_barrel_shift_seq.sv
// Directed self-checking bench for barrel_shift_seq (WIDTH=8, STEP=1 and STEP=4).
// Carry checks are compiled in when BSR_CARRY_EN is defined.
module tb_barrel_shift_seq;

   logic       clock;
   logic       reset;

   logic       load1, start1;
   logic [7:0] data_in1;
   logic [2:0] mode1;
   logic [3:0] amount1;
   logic [7:0] data_out1;
   logic       busy1, done1;

   logic       load4, start4;
   logic [7:0] data_in4;
   logic [2:0] mode4;
   logic [3:0] amount4;
   logic [7:0] data_out4;
   logic       busy4, done4;

`ifdef BSR_CARRY_EN
   logic       carry1, carry4;
`endif

   int checks = 0;
   int errors = 0;

   barrel_shift_seq #(.WIDTH(8), .STEP(1)) dut1 (
      .clock(clock), .reset(reset), .load(load1), .data_in(data_in1),
      .start(start1), .mode(mode1), .amount(amount1), .data_out(data_out1),
`ifdef BSR_CARRY_EN
      .busy(busy1), .done(done1), .carry_out(carry1)
`else
      .busy(busy1), .done(done1)
`endif
   );

   barrel_shift_seq #(.WIDTH(8), .STEP(4)) dut4 (
      .clock(clock), .reset(reset), .load(load4), .data_in(data_in4),
      .start(start4), .mode(mode4), .amount(amount4), .data_out(data_out4),
`ifdef BSR_CARRY_EN
      .busy(busy4), .done(done4), .carry_out(carry4)
`else
      .busy(busy4), .done(done4)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue a command on dut1 and wait (bounded) for done; counts busy samples.
   task automatic run_cmd1(input logic [2:0] m, input logic [3:0] amt,
                           output int busy_n, output bit seen);
      start1 = 1'b1; mode1 = m; amount1 = amt;
      tick();
      start1 = 1'b0;
      busy_n = 0; seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done1) begin seen = 1'b1; break; end
         if (busy1) busy_n++;
         tick();
      end
   endtask

   task automatic run_cmd4(input logic [2:0] m, input logic [3:0] amt,
                           output int busy_n, output bit seen);
      start4 = 1'b1; mode4 = m; amount4 = amt;
      tick();
      start4 = 1'b0;
      busy_n = 0; seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done4) begin seen = 1'b1; break; end
         if (busy4) busy_n++;
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      checks++; if (data_out1 !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out1); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy1); end
      checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done1); end
      checks++; if (data_out4 !== 8'h00) begin errors++; $display("FAIL reset_data4 got %h want 00", data_out4); end
`ifdef BSR_CARRY_EN
      checks++; if (carry1 !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", carry1); end
`endif
      reset = 1'b0;
      tick();
   endtask

   task automatic test_rol();
      int bn; bit seen;
      load1 = 1'b1; data_in1 = 8'hA5;
      tick();
      load1 = 1'b0;
      checks++; if (data_out1 !== 8'hA5) begin errors++; $display("FAIL rol_load got %h want A5", data_out1); end
      run_cmd1(3'b000, 4'd1, bn, seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rol_done_timeout got %b want 1", seen); end
      checks++; if (bn !== 1) begin errors++; $display("FAIL rol_busy_cycles got %0d want 1", bn); end
      checks++; if (data_out1 !== 8'h4B) begin errors++; $display("FAIL rol_data got %h want 4B", data_out1); end
`ifdef BSR_CARRY_EN
      checks++; if (carry1 !== 1'b1) begin errors++; $display("FAIL rol_carry got %b want 1", carry1); end
`endif
      tick();
      checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL rol_done_pulse got %b want 0", done1); end
   endtask

   task automatic test_reserved();
      int bn; bit seen;
      run_cmd1(3'b111, 4'd2, bn, seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rsv_done_timeout got %b want 1", seen); end
      checks++; if (bn !== 2) begin errors++; $display("FAIL rsv_busy_cycles got %0d want 2", bn); end
      checks++; if (data_out1 !== 8'h4B) begin errors++; $display("FAIL rsv_data got %h want 4B", data_out1); end
`ifdef BSR_CARRY_EN
      checks++; if (carry1 !== 1'b1) begin errors++; $display("FAIL rsv_carry got %b want 1", carry1); end
`endif
      tick();
   endtask

   task automatic test_ror();
      load1 = 1'b1; data_in1 = 8'h81;
      tick();
      load1 = 1'b0;
      start1 = 1'b1; mode1 = 3'b001; amount1 = 4'd3;
      tick();
      start1 = 1'b0;
      checks++; if (busy1 !== 1'b1 || data_out1 !== 8'h81) begin errors++; $display("FAIL ror_s0 got busy=%b data=%h want busy=1 data=81", busy1, data_out1); end
      tick();
      checks++; if (busy1 !== 1'b1 || data_out1 !== 8'hC0) begin errors++; $display("FAIL ror_s1 got busy=%b data=%h want busy=1 data=C0", busy1, data_out1); end
`ifdef BSR_CARRY_EN
      checks++; if (carry1 !== 1'b1) begin errors++; $display("FAIL ror_carry1 got %b want 1", carry1); end
`endif
      tick();
      checks++; if (busy1 !== 1'b1 || data_out1 !== 8'h60) begin errors++; $display("FAIL ror_s2 got busy=%b data=%h want busy=1 data=60", busy1, data_out1); end
      tick();
      checks++; if (busy1 !== 1'b0 || done1 !== 1'b1 || data_out1 !== 8'h30) begin errors++; $display("FAIL ror_s3 got busy=%b done=%b data=%h want busy=0 done=1 data=30", busy1, done1, data_out1); end
`ifdef BSR_CARRY_EN
      checks++; if (carry1 !== 1'b0) begin errors++; $display("FAIL ror_carry3 got %b want 0", carry1); end
`endif
      tick();
      checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL ror_done_pulse got %b want 0", done1); end
   endtask

   task automatic test_clamp();
      int bn; bit seen;
      load1 = 1'b1; data_in1 = 8'hFF;
      tick();
      load1 = 1'b0;
      run_cmd1(3'b010, 4'd9, bn, seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL clamp_done_timeout got %b want 1", seen); end
      checks++; if (bn !== 8) begin errors++; $display("FAIL clamp_busy_cycles got %0d want 8", bn); end
      checks++; if (data_out1 !== 8'h00) begin errors++; $display("FAIL clamp_data got %h want 00", data_out1); end
`ifdef BSR_CARRY_EN
      checks++; if (carry1 !== 1'b1) begin errors++; $display("FAIL clamp_carry got %b want 1", carry1); end
`endif
      tick();
      run_cmd1(3'b000, 4'd0, bn, seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL zero_done_timeout got %b want 1", seen); end
      checks++; if (bn !== 0) begin errors++; $display("FAIL zero_busy_cycles got %0d want 0", bn); end
      checks++; if (data_out1 !== 8'h00) begin errors++; $display("FAIL zero_data got %h want 00", data_out1); end
`ifdef BSR_CARRY_EN
      checks++; if (carry1 !== 1'b1) begin errors++; $display("FAIL zero_carry got %b want 1", carry1); end
`endif
      tick();
   endtask

   task automatic test_back_to_back();
      int bn; bit seen;
      load1 = 1'b1; data_in1 = 8'h01;
      tick();
      load1 = 1'b0;
      run_cmd1(3'b000, 4'd1, bn, seen);
      checks++; if (seen !== 1'b1 || data_out1 !== 8'h02) begin errors++; $display("FAIL b2b_first got seen=%b data=%h want seen=1 data=02", seen, data_out1); end
      // Held in DONE (ignored) and then in the following IDLE cycle (accepted).
      start1 = 1'b1; mode1 = 3'b000; amount1 = 4'd1;
      tick();
      checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL b2b_done_ignore got busy=%b done=%b want busy=0 done=0", busy1, done1); end
      tick();
      start1 = 1'b0;
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", busy1); end
      tick();
      checks++; if (done1 !== 1'b1 || data_out1 !== 8'h04) begin errors++; $display("FAIL b2b_second got done=%b data=%h want done=1 data=04", done1, data_out1); end
      tick();
   endtask

   task automatic test_load_start();
      load1 = 1'b1; start1 = 1'b1; data_in1 = 8'h3C; mode1 = 3'b000; amount1 = 4'd2;
      tick();
      load1 = 1'b0; start1 = 1'b0;
      checks++; if (data_out1 !== 8'h3C || busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL ldst_edge got data=%h busy=%b done=%b want 3C 0 0", data_out1, busy1, done1); end
      tick();
      checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL ldst_dropped got busy=%b done=%b want 0 0", busy1, done1); end
      start1 = 1'b1; mode1 = 3'b000; amount1 = 4'd2;
      tick();
      start1 = 1'b0;
      checks++; if (busy1 !== 1'b1 || data_out1 !== 8'h3C) begin errors++; $display("FAIL ldst_go got busy=%b data=%h want 1 3C", busy1, data_out1); end
      start1 = 1'b1; load1 = 1'b1; data_in1 = 8'h00; mode1 = 3'b011; amount1 = 4'd5;
      tick();
      start1 = 1'b0; load1 = 1'b0;
      checks++; if (busy1 !== 1'b1 || data_out1 !== 8'h78) begin errors++; $display("FAIL ldst_shift_ignore got busy=%b data=%h want 1 78", busy1, data_out1); end
      tick();
      checks++; if (done1 !== 1'b1 || data_out1 !== 8'hF0) begin errors++; $display("FAIL ldst_final got done=%b data=%h want 1 F0", done1, data_out1); end
      tick(); tick();
      checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL ldst_no_queue got busy=%b done=%b want 0 0", busy1, done1); end
   endtask

   task automatic test_step4();
      int bn; bit seen;
      load4 = 1'b1; data_in4 = 8'h90;
      tick();
      load4 = 1'b0;
      run_cmd4(3'b100, 4'd4, bn, seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL s4_sra_timeout got %b want 1", seen); end
      checks++; if (bn !== 1) begin errors++; $display("FAIL s4_sra_busy got %0d want 1", bn); end
      checks++; if (data_out4 !== 8'hF9) begin errors++; $display("FAIL s4_sra_data got %h want F9", data_out4); end
`ifdef BSR_CARRY_EN
      checks++; if (carry4 !== 1'b0) begin errors++; $display("FAIL s4_sra_carry got %b want 0", carry4); end
`endif
      tick();
      checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL s4_done_once got %b want 0", done4); end
      load4 = 1'b1; data_in4 = 8'hA5;
      tick();
      load4 = 1'b0;
      run_cmd4(3'b000, 4'd8, bn, seen);
      checks++; if (bn !== 2 || seen !== 1'b1) begin errors++; $display("FAIL s4_rol8_busy got %0d seen=%b want 2 seen=1", bn, seen); end
      checks++; if (data_out4 !== 8'hA5) begin errors++; $display("FAIL s4_rol8_data got %h want A5", data_out4); end
`ifdef BSR_CARRY_EN
      checks++; if (carry4 !== 1'b1) begin errors++; $display("FAIL s4_rol8_carry got %b want 1", carry4); end
`endif
      tick();
      load4 = 1'b1; data_in4 = 8'hF0;
      tick();
      load4 = 1'b0;
      run_cmd4(3'b011, 4'd3, bn, seen);
      checks++; if (bn !== 1 || seen !== 1'b1 || data_out4 !== 8'h1E) begin errors++; $display("FAIL s4_srl got busy=%0d seen=%b data=%h want 1 1 1E", bn, seen, data_out4); end
      tick();
   endtask

   task automatic test_reset_mid();
      int dn, bn;
      load1 = 1'b1; data_in1 = 8'h80;
      tick();
      load1 = 1'b0;
      start1 = 1'b1; mode1 = 3'b000; amount1 = 4'd5;
      tick();
      start1 = 1'b0;
      tick();
      checks++; if (busy1 !== 1'b1 || data_out1 !== 8'h01) begin errors++; $display("FAIL rmid_pre got busy=%b data=%h want 1 01", busy1, data_out1); end
      #2 reset = 1'b1;
      #1;
      checks++; if (data_out1 !== 8'h00 || busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL rmid_async got data=%h busy=%b done=%b want 00 0 0", data_out1, busy1, done1); end
`ifdef BSR_CARRY_EN
      checks++; if (carry1 !== 1'b0) begin errors++; $display("FAIL rmid_carry got %b want 0", carry1); end
`endif
      tick();
      reset = 1'b0;
      dn = 0; bn = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done1) dn++;
         if (busy1) bn++;
      end
      checks++; if (dn !== 0 || bn !== 0) begin errors++; $display("FAIL rmid_after got done_n=%0d busy_n=%0d want 0 0", dn, bn); end
   endtask

   initial begin
      reset = 1'b1;
      load1 = 1'b0; start1 = 1'b0; data_in1 = '0; mode1 = '0; amount1 = '0;
      load4 = 1'b0; start4 = 1'b0; data_in4 = '0; mode4 = '0; amount4 = '0;
      test_reset();
      test_rol();
      test_reserved();
      test_ror();
      test_clamp();
      test_back_to_back();
      test_load_start();
      test_step4();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
